// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer result FIFOs feeding one registered CDB broadcast via round-robin grant.
// Define CDB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (producer 0 highest).
module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int DEPTH     = 2,
    parameter int ROB_WIDTH = 5
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           _clear,
    input  logic [NUM_REQ-1:0]             _req_valid,
    input  logic [NUM_REQ*ROB_WIDTH-1:0]   _req_rob_id,
    input  logic [NUM_REQ*32-1:0]          _req_value,
    output logic [NUM_REQ-1:0]             _req_full,
    output logic                           _cdb_ready,
    output logic [ROB_WIDTH-1:0]           _cdb_rob_id,
    output logic [31:0]                    _cdb_value,
    output logic [1:0]                     _cdb_src
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ROB_WIDTH + 32;

    logic [EW-1:0]        mem_q  [NUM_REQ][DEPTH];
    logic [EW-1:0]        mem_d  [NUM_REQ][DEPTH];
    logic [PW-1:0]        head_q [NUM_REQ];
    logic [PW-1:0]        head_d [NUM_REQ];
    logic [PW-1:0]        tail_q [NUM_REQ];
    logic [PW-1:0]        tail_d [NUM_REQ];
    logic [CW-1:0]        cnt_q  [NUM_REQ];
    logic [CW-1:0]        cnt_d  [NUM_REQ];
    logic                 ready_q, ready_d;
    logic [ROB_WIDTH-1:0] rob_q, rob_d;
    logic [31:0]          value_q, value_d;
    logic [1:0]           src_q, src_d;
    logic [1:0]           rr_q, rr_d;
    logic [1:0]           start, idx, grant;
    logic                 grant_vld, push, pop;
    logic [EW-1:0]        head_entry;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    assign start = rr_q;
`endif

    assign _cdb_ready  = ready_q;
    assign _cdb_rob_id = rob_q;
    assign _cdb_value  = value_q;
    assign _cdb_src    = src_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) _req_full[i] = cnt_q[i] == CW'(DEPTH);
    end

    // Scan from the highest offset down so the last hit is the first candidate after start.
    always_comb begin
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = 2'((int'(start) + k) % NUM_REQ);
            if (cnt_q[idx] != '0) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign head_entry = mem_q[grant][head_q[grant]];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        rob_d   = rob_q;
        value_d = value_q;
        src_d   = src_q;
        rr_d    = rr_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (rdy_in && _clear) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                head_d[i] = '0;
                tail_d[i] = '0;
                cnt_d[i]  = '0;
            end
            ready_d = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push = _req_valid[i] && !_req_full[i];
                pop  = grant_vld && grant == 2'(i);
                if (push) begin
                    mem_d[i][tail_q[i]] = {_req_rob_id[i*ROB_WIDTH +: ROB_WIDTH], _req_value[i*32 +: 32]};
                    tail_d[i] = tail_q[i] + PW'(1);
                end
                if (pop) head_d[i] = head_q[i] + PW'(1);
                cnt_d[i] = cnt_q[i] + CW'(push) - CW'(pop);
            end
            ready_d = grant_vld;
            rob_d   = grant_vld ? head_entry[EW-1:32] : rob_q;
            value_d = grant_vld ? head_entry[31:0] : value_q;
            src_d   = grant_vld ? grant : src_q;
            rr_d    = !grant_vld ? rr_q : (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_q   <= '{default: '0};
            head_q  <= '{default: '0};
            tail_q  <= '{default: '0};
            cnt_q   <= '{default: '0};
            ready_q <= 1'b0;
            rob_q   <= '0;
            value_q <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rob_q   <= rob_d;
            value_q <= value_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end
endmodule
